// File: rtl/clint_arbiter.sv
// Two-requester round-robin arbiter in front of a single CLINT slave port.
// One transaction in flight at a time; slave silence beyond TIMEOUT cycles becomes an access fault.
package clint_arbiter_pkg;
  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'd0,
    SIZE_HALF   = 2'd1,
    SIZE_WORD   = 2'd2,
    SIZE_DOUBLE = 2'd3
  } mem_access_size_t;
endpackage

module clint_arbiter
  import clint_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_valid_i,
  input  logic [63:0]      m0_addr_i,
  input  mem_access_size_t m0_byte_en_i,
  input  logic             m0_wr_i,
  input  logic [63:0]      m0_wr_data_i,
  output logic             m0_ready_o,
  output logic [63:0]      m0_data_o,
  output logic             m0_resp_valid_o,
  output logic             m0_exc_valid_o,
  output logic [4:0]       m0_exc_code_o,
  input  logic             m1_valid_i,
  input  logic [63:0]      m1_addr_i,
  input  mem_access_size_t m1_byte_en_i,
  input  logic             m1_wr_i,
  input  logic [63:0]      m1_wr_data_i,
  output logic             m1_ready_o,
  output logic [63:0]      m1_data_o,
  output logic             m1_resp_valid_o,
  output logic             m1_exc_valid_o,
  output logic [4:0]       m1_exc_code_o,
  output logic [63:0]      s_addr_o,
  output logic             s_valid_o,
  output mem_access_size_t s_byte_en_o,
  output logic             s_wr_o,
  output logic [63:0]      s_wr_data_o,
  input  logic             s_ready_i,
  input  logic [63:0]      s_data_i,
  input  logic             s_resp_valid_i,
  input  logic             s_exc_valid_i,
  input  logic [4:0]       s_exc_code_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic             prio;      // requester favoured on contention
  logic             owner;
  logic [63:0]      addr_q;
  logic [63:0]      wdata_q;
  mem_access_size_t size_q;
  logic             wr_q;
  logic [63:0]      data_q;
  logic             exc_q;
  logic [4:0]       code_q;
  logic [7:0]       cnt;

  logic             grant_valid;
  logic             grant_id;
  logic             s_hit;
  logic [63:0]      cap_data;
  logic [4:0]       cap_code;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    grant_valid = m0_valid_i | m1_valid_i;
    grant_id    = m1_valid_i;
    if (m0_valid_i && m1_valid_i) grant_id = prio;
  end

  // Exception wins over data; stores never return data.
  assign s_hit    = s_resp_valid_i | s_exc_valid_i;
  assign cap_data = (s_exc_valid_i || wr_q) ? 64'd0 : s_data_i;
  assign cap_code = s_exc_valid_i ? s_exc_code_i : 5'd0;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      prio    <= 1'b0;
      owner   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SIZE_BYTE;
      wr_q    <= 1'b0;
      data_q  <= '0;
      exc_q   <= 1'b0;
      code_q  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (grant_valid) begin
          owner   <= grant_id;
          addr_q  <= grant_id ? m1_addr_i    : m0_addr_i;
          wdata_q <= grant_id ? m1_wr_data_i : m0_wr_data_i;
          size_q  <= grant_id ? m1_byte_en_i : m0_byte_en_i;
          wr_q    <= grant_id ? m1_wr_i      : m0_wr_i;
          state   <= ISSUE;
        end
        ISSUE: if (s_ready_i) begin
          if (s_hit) begin
            data_q <= cap_data;
            exc_q  <= s_exc_valid_i;
            code_q <= cap_code;
            state  <= RESP;
          end else begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (s_hit) begin
            data_q <= cap_data;
            exc_q  <= s_exc_valid_i;
            code_q <= cap_code;
            state  <= RESP;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            data_q <= '0;
            exc_q  <= 1'b1;
            code_q <= wr_q ? 5'd7 : 5'd5;
            state  <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          prio  <= ~owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic issue_on, m0_sel, m1_sel;
  assign issue_on = (state == ISSUE) && !reset;
  assign m0_sel   = (state == RESP) && !reset && !owner;
  assign m1_sel   = (state == RESP) && !reset &&  owner;

  assign m0_ready_o = (state == IDLE) && !reset && grant_valid && !grant_id;
  assign m1_ready_o = (state == IDLE) && !reset && grant_valid &&  grant_id;

  assign s_valid_o   = issue_on;
  assign s_addr_o    = issue_on ? addr_q  : '0;
  assign s_wr_data_o = issue_on ? wdata_q : '0;
  assign s_wr_o      = issue_on && wr_q;
  assign s_byte_en_o = issue_on ? size_q  : SIZE_BYTE;

  assign m0_resp_valid_o = m0_sel && !exc_q;
  assign m0_exc_valid_o  = m0_sel &&  exc_q;
  assign m0_exc_code_o   = m0_sel ? code_q : '0;
  assign m0_data_o       = m0_sel ? data_q : '0;
  assign m1_resp_valid_o = m1_sel && !exc_q;
  assign m1_exc_valid_o  = m1_sel &&  exc_q;
  assign m1_exc_code_o   = m1_sel ? code_q : '0;
  assign m1_data_o       = m1_sel ? data_q : '0;

endmodule

// File: tb/tb_clint_arbiter.sv
// Randomized transaction-level bench for clint_arbiter: each transaction's timeline
// (grant, issue, wait, response) is predicted from the slave behaviour the bench chooses.
module tb_clint_arbiter;
  import clint_arbiter_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]       v;
  logic [63:0]      addr [2];
  mem_access_size_t size [2];
  logic             wr   [2];
  logic [63:0]      wdat [2];
  logic             s_ready, s_rv, s_ev;
  logic [63:0]      s_data;
  logic [4:0]       s_code;

  logic             m0_ready, m1_ready, m0_rv, m1_rv, m0_ev, m1_ev;
  logic [4:0]       m0_code, m1_code;
  logic [63:0]      m0_data, m1_data;
  logic             s_valid, s_wr;
  mem_access_size_t s_size;
  logic [63:0]      s_addr, s_wdata;

  int total = 0;
  int bad   = 0;
  int last_own;

  clint_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_valid_i(v[0]), .m0_addr_i(addr[0]), .m0_byte_en_i(size[0]), .m0_wr_i(wr[0]),
    .m0_wr_data_i(wdat[0]), .m0_ready_o(m0_ready), .m0_data_o(m0_data),
    .m0_resp_valid_o(m0_rv), .m0_exc_valid_o(m0_ev), .m0_exc_code_o(m0_code),
    .m1_valid_i(v[1]), .m1_addr_i(addr[1]), .m1_byte_en_i(size[1]), .m1_wr_i(wr[1]),
    .m1_wr_data_i(wdat[1]), .m1_ready_o(m1_ready), .m1_data_o(m1_data),
    .m1_resp_valid_o(m1_rv), .m1_exc_valid_o(m1_ev), .m1_exc_code_o(m1_code),
    .s_addr_o(s_addr), .s_valid_o(s_valid), .s_byte_en_o(s_size), .s_wr_o(s_wr),
    .s_wr_data_o(s_wdata), .s_ready_i(s_ready), .s_data_i(s_data),
    .s_resp_valid_i(s_rv), .s_exc_valid_i(s_ev), .s_exc_code_i(s_code)
  );

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [70:0] mout(input int n);
    return (n == 0) ? {m0_rv, m0_ev, m0_code, m0_data} : {m1_rv, m1_ev, m1_code, m1_data};
  endfunction

  function automatic logic [131:0] sout();
    return {s_valid, s_wr, s_size, s_addr, s_wdata};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req();
    for (int i = 0; i < 2; i++) begin
      addr[i] = {$urandom, $urandom};
      size[i] = mem_access_size_t'($urandom_range(0, 3));
      wr[i]   = 1'($urandom_range(0, 1));
      wdat[i] = {$urandom, $urandom};
    end
  endtask

  task automatic quiet_slave();
    s_ready = 1'($urandom_range(0, 1));
    s_rv    = 1'b0;
    s_ev    = 1'b0;
    s_code  = 5'($urandom);
    s_data  = {$urandom, $urandom};
  endtask

  // Everything quiet: no ready, no slave request, no response strobes.
  task automatic check_quiet(input string tag);
    check({tag, "_rdy"}, {m0_ready, m1_ready}, 2'b00);
    check({tag, "_s"}, sout(), '0);
    check({tag, "_m0"}, mout(0), '0);
    check({tag, "_m1"}, mout(1), '0);
  endtask

  // d = 0: response with the accepting s_ready; 1..TO: on that WAIT cycle; > TO: never.
  task automatic run_txn(input logic [1:0] vv, input int k, input int d, input logic rv,
                         input logic ev, input logic [4:0] code, input logic [63:0] sdata);
    int own, waits;
    logic [63:0] ea, ewd, ed;
    logic ew, eexc;
    logic [4:0] ec;
    mem_access_size_t es;

    v = vv;
    quiet_slave();
    own = (vv == 2'b11) ? ((last_own == 0) ? 1 : 0) : (vv[1] ? 1 : 0);
    ea = addr[own]; ewd = wdat[own]; ew = wr[own]; es = size[own];
    #1;
    check("grant", {m0_ready, m1_ready}, (own == 0) ? 2'b10 : 2'b01);
    check("acc_s", sout(), '0);
    check("acc_m", {mout(0), mout(1)}, '0);
    next_cycle();

    for (int i = 0; i <= k; i++) begin
      rand_req();
      quiet_slave();
      s_ready = (i == k);
      if (i == k && d == 0) begin
        s_rv = rv; s_ev = ev; s_code = code; s_data = sdata;
      end
      #1;
      check("issue_s", sout(), {1'b1, ew, es, ea, ewd});
      check("issue_rdy", {m0_ready, m1_ready}, 2'b00);
      check("issue_m", {mout(0), mout(1)}, '0);
      next_cycle();
    end

    if (d != 0) begin
      waits = (d > TO) ? TO : d;
      for (int j = 1; j <= waits; j++) begin
        quiet_slave();
        if (j == d) begin
          s_rv = rv; s_ev = ev; s_code = code; s_data = sdata;
        end
        #1;
        check_quiet($sformatf("wait%0d", j));
        next_cycle();
      end
    end

    if (d > TO) begin
      eexc = 1'b1; ec = ew ? 5'd7 : 5'd5; ed = '0;
    end else begin
      eexc = ev; ec = ev ? code : 5'd0; ed = (ev || ew) ? 64'd0 : sdata;
    end

    quiet_slave();
    #1;
    check($sformatf("resp_own_m%0d", own), mout(own), {!eexc, eexc, ec, ed});
    check("resp_other", mout(1 - own), '0);
    check("resp_rdy", {m0_ready, m1_ready}, 2'b00);
    check("resp_s", sout(), '0);
    last_own = own;
    next_cycle();
  endtask

  initial begin
    int k, d, sel;
    logic [1:0] vv;
    logic rv, ev;

    reset = 1'b1;
    v = 2'b00;
    rand_req();
    quiet_slave();
    repeat (3) next_cycle();
    v = 2'b11;
    s_rv = 1'b1;
    #1;
    check_quiet("in_reset");
    next_cycle();
    reset = 1'b0;
    v = 2'b00;
    quiet_slave();
    #1;
    check_quiet("post_reset");
    next_cycle();
    last_own = 1;

    // Plain load, single-cycle slave.
    addr[0] = 64'h1_0000; wr[0] = 1'b0;
    run_txn(2'b01, 0, 0, 1'b1, 1'b0, 5'd0, 64'd1);

    // Continuous contention alternates m1, m0, m1, m0 after m0 was last served.
    for (int i = 0; i < 4; i++) begin
      rand_req();
      run_txn(2'b11, 0, 0, 1'b1, 1'b0, 5'd0, {$urandom, $urandom});
    end

    // Store from m1 with three stalled ISSUE cycles.
    rand_req();
    addr[1] = 64'h1_4000; wr[1] = 1'b1;
    run_txn(2'b10, 3, 0, 1'b1, 1'b0, 5'd0, 64'hdead_beef);

    // Timeout on store and on load.
    rand_req(); wr[0] = 1'b1;
    run_txn(2'b01, 0, TO + 1, 1'b0, 1'b0, 5'd0, '0);
    rand_req(); wr[0] = 1'b0;
    run_txn(2'b01, 1, TO + 1, 1'b0, 1'b0, 5'd0, '0);

    // Response on the last WAIT cycle still counts as a response.
    rand_req(); wr[1] = 1'b0;
    run_txn(2'b10, 0, TO, 1'b1, 1'b0, 5'd0, {$urandom, $urandom});

    // Simultaneous exception and data: exception wins.
    rand_req(); wr[0] = 1'b0;
    run_txn(2'b01, 0, 0, 1'b1, 1'b1, 5'd5, 64'h1234);

    // Reset in WAIT: m0 served last so the pointer favours m1 until reset restores m0.
    rand_req();
    run_txn(2'b01, 0, 0, 1'b1, 1'b0, 5'd0, 64'h55);
    rand_req();
    v = 2'b10;
    quiet_slave();
    #1;
    check("rst_grant", {m0_ready, m1_ready}, 2'b01);
    next_cycle();
    quiet_slave(); s_ready = 1'b1;
    #1;
    check("rst_issue", s_valid, 1'b1);
    next_cycle();
    quiet_slave();
    #1;
    check_quiet("rst_wait");
    next_cycle();
    reset = 1'b1;
    v = 2'b11;
    quiet_slave(); s_rv = 1'b1; s_ev = 1'b1;
    #1;
    check_quiet("rst_mid");
    next_cycle();
    reset = 1'b0;
    v = 2'b00;
    quiet_slave();
    #1;
    check_quiet("rst_after");
    next_cycle();
    last_own = 1;
    rand_req();
    run_txn(2'b11, 0, 0, 1'b1, 1'b0, 5'd0, {$urandom, $urandom});

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = 2'b00;
        quiet_slave();
        #1;
        check_quiet("idle");
        next_cycle();
      end
      rand_req();
      vv  = 2'($urandom_range(1, 3));
      k   = $urandom_range(0, 3);
      sel = $urandom_range(0, 9);
      d   = (sel < 4) ? 0 : (sel < 8) ? $urandom_range(1, 4) : (sel == 8) ? TO : TO + 1;
      rv  = 1'($urandom_range(0, 1));
      ev  = 1'($urandom_range(0, 1));
      if (!rv && !ev) rv = 1'b1;
      run_txn(vv, k, d, rv, ev, 5'($urandom), {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
